sma_calc: RTL
=============

# sma_calc

Moving-average front end of the trading pipeline. Accepts the raw price stream, keeps a circular history of the last LONG_LEN samples, and maintains running sums for a short and a long simple moving average. Each accepted sample produces a registered `short_sma`, `long_sma`, `current_data` and a one-cycle `data_valid_pre` pulse. These outputs feed the mean-reversion/trend decision stage directly.

## Interface
- `data_width`, 8: width of price samples and of both SMA outputs.
- `SHORT_LEN`, 4: short window length in samples; power of two, ≥2.
- `LONG_LEN`, 16: long window length in samples; power of two, > SHORT_LEN.

- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  reset, asynchronous and active-low; one clock, fixed polarity and synchronicity.
- `clear`  input  1  synchronous flush of history; same effect as reset, but on a clock edge.
- `price_in`  input  data_width  incoming price sample.
- `price_valid`  input  1  `price_in` is accepted on this edge; no backpressure.
- `short_sma`  output  data_width  floor(mean of last SHORT_LEN samples).
- `long_sma`  output  data_width  floor(mean of last LONG_LEN samples).
- `current_data`  output  data_width  the sample that produced the current outputs.
- `data_valid_pre`  output  1  one-cycle pulse: outputs updated and window full.

## Operation
- History: LONG_LEN × data_width ring, write pointer `wr_ptr` (log2(LONG_LEN) bits, wraps modulo LONG_LEN).
- Sum widths:
  - `sum_long` is data_width+log2(LONG_LEN) bits.
  - `sum_short` is data_width+log2(SHORT_LEN) bits.
  - Neither can overflow.
- On an edge with `price_valid`=1:
  - `old_l` = ring[wr_ptr]; `old_s` = ring[(wr_ptr−SHORT_LEN) mod LONG_LEN].
  - `sum_long` ← sum_long + price_in − old_l.
  - `sum_short` ← sum_short + price_in − old_s.
  - ring[wr_ptr] ← price_in; wr_ptr ← wr_ptr+1.
- Division is a right shift by log2(LEN) of the *updated* sum, so the outputs include the new sample. Results truncate toward zero.
- Ring contents reset to 0, so subtracting unfilled entries during warm-up is exact.
- State machine (enum in package):
  - FILL: counts accepted samples in `fill_cnt` (0..LONG_LEN−1). When the LONG_LEN-th sample is accepted, go to RUN; that sample's edge asserts `data_valid_pre`.
  - RUN: every accepted sample asserts `data_valid_pre`. Stays in RUN until `rst` or `clear`.
- Output registers `short_sma`, `long_sma`, `current_data` update on every accepted sample, including in FILL, but are only qualified by `data_valid_pre`. They hold their value when `price_valid`=0.
- `clear`: zeroes ring, sums, pointer, `fill_cnt`, all outputs; state ← FILL. `clear` has priority over `price_valid` on the same edge (the sample is dropped).
- `rst` low: immediate, same zeroed state as `clear`, independent of clk.

## Timing
- Latency: sample presented with `price_valid` at edge N → outputs and `data_valid_pre` visible after edge N, for exactly one cycle of valid.
- Throughput: one sample per cycle sustained; gaps of any length allowed, and the history does not age during gaps.
- Reset value of every output: 0; state FILL.
- First valid pulse: on the LONG_LEN-th accepted sample after reset/clear, never earlier.
- Wrap: behaviour across `wr_ptr` LONG_LEN−1→0 is identical to non-wrap; the short-window index wraps negative correctly.
- Reset or `clear` mid-stream: the pulse in flight is suppressed, and warm-up restarts from zero.

## Structure
- Package `sma_pkg`:
  - state enum {FILL, RUN};
  - localparam width helpers (ptr width, sum widths via $clog2).
- One sub-module, `sample_ring`: LONG_LEN-deep register ring with async active-low reset and sync clear, one write port, two combinational read ports (long-tail, short-tail).
- Top level holds sums, FSM, and output registers.

## Test plan
1. Ramp 1..16, consecutive cycles (default params): no pulse for samples 1–15. On the 16th: `long_sma`=8 (136>>4), `short_sma`=14 (58>>2), `current_data`=16, one-cycle pulse.
2. 16×0 then 200: `short_sma`=50, `long_sma`=12, valid. Then 3 more 200s: `short_sma`=200, `long_sma`=50.
3. Constant 255 for 40 samples, with random gaps in `price_valid`: both SMAs 255 on every pulse, and exactly 25 pulses. Covers no overflow and wrap twice.
4. Assert `rst` low asynchronously after 20 samples, then release: outputs 0 immediately, and the next 15 samples give no pulse.
5. `clear` together with `price_valid` in RUN: sample dropped, outputs 0, state FILL; the pulse returns only after 16 new samples.
6. Random stream of 1000 samples checked against a reference model of the floor averages over the sliding window.

Source files
------------

// File: rtl/sma_pkg.sv
// Shared types and width helpers for the moving-average front end.
// The width helpers are constant functions so each module can size its own state.
package sma_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } sma_state_e;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_SHORT_LEN = 4;
   localparam int DEF_LONG_LEN  = 16;

   function automatic int ptr_width(input int len);
      return $clog2(len);
   endfunction

   function automatic int sum_width(input int data_w, input int len);
      return data_w + $clog2(len);
   endfunction

endpackage : sma_pkg

// File: rtl/sample_ring.sv
// Register ring holding the last DEPTH samples. It has one write port and two
// combinational taps: the slot about to be overwritten, and the slot SHORT_LEN samples back.
module sample_ring
   import sma_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_LONG_LEN,
   parameter int SHORT_LEN = DEF_SHORT_LEN,
   localparam int PTR_W    = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              wr_en_i,
   input  logic [PTR_W-1:0]  wr_ptr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] long_tail_o,
   output logic [DATA_W-1:0] short_tail_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  short_idx;

   // Unsigned pointer arithmetic wraps modulo DEPTH, so a negative short index lands correctly.
   assign short_idx    = wr_ptr_i - PTR_W'(SHORT_LEN);
   assign long_tail_o  = mem_q[wr_ptr_i];
   assign short_tail_o = mem_q[short_idx];

   // NOTE: this memory is reset, unlike a normal RAM. The running sums subtract unfilled
   // slots during warm-up, and that subtraction is only exact if those slots hold zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_ptr_i] <= wr_data_i;
      end
   end

endmodule : sample_ring

// File: rtl/sma_calc.sv
// Short/long simple moving averages over a circular price history.
// Each accepted sample updates both running sums and registers the floor averages.
module sma_calc
   import sma_pkg::*;
#(
   parameter int data_width = DEF_DATA_W,
   parameter int SHORT_LEN  = DEF_SHORT_LEN,
   parameter int LONG_LEN   = DEF_LONG_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [data_width-1:0] price_in,
   input  logic                  price_valid,
   output logic [data_width-1:0] short_sma,
   output logic [data_width-1:0] long_sma,
   output logic [data_width-1:0] current_data,
   output logic                  data_valid_pre
);

   localparam int PTR_W   = ptr_width(LONG_LEN);
   localparam int LOG_S   = ptr_width(SHORT_LEN);
   localparam int SUM_L_W = sum_width(data_width, LONG_LEN);
   localparam int SUM_S_W = sum_width(data_width, SHORT_LEN);
   localparam logic [PTR_W-1:0] LAST_FILL = PTR_W'(LONG_LEN - 1);

   sma_state_e            state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      fill_cnt_q, fill_cnt_d;
   logic [SUM_L_W-1:0]    sum_long_q, sum_long_d;
   logic [SUM_S_W-1:0]    sum_short_q, sum_short_d;
   logic [data_width-1:0] short_sma_q, short_sma_d;
   logic [data_width-1:0] long_sma_q, long_sma_d;
   logic [data_width-1:0] current_q, current_d;
   logic                  valid_q, valid_d;

   logic [data_width-1:0] old_l, old_s;

   sample_ring #(
      .DATA_W   (data_width),
      .DEPTH    (LONG_LEN),
      .SHORT_LEN(SHORT_LEN)
   ) u_ring (
      .clk         (clk),
      .rst_n       (rst),
      .clear_i     (clear),
      .wr_en_i     (price_valid),
      .wr_ptr_i    (wr_ptr_q),
      .wr_data_i   (price_in),
      .long_tail_o (old_l),
      .short_tail_o(old_s)
   );

   // NOTE: every signal gets its hold value first, so no path through this block
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      sum_long_d  = sum_long_q;
      sum_short_d = sum_short_q;
      short_sma_d = short_sma_q;
      long_sma_d  = long_sma_q;
      current_d   = current_q;
      valid_d     = 1'b0;

      if (clear) begin
         state_d     = FILL;
         wr_ptr_d    = '0;
         fill_cnt_d  = '0;
         sum_long_d  = '0;
         sum_short_d = '0;
         short_sma_d = '0;
         long_sma_d  = '0;
         current_d   = '0;
      end else if (price_valid) begin
         // The sums always contain the outgoing sample, so the subtraction cannot underflow.
         sum_long_d  = sum_long_q + SUM_L_W'(price_in) - SUM_L_W'(old_l);
         sum_short_d = sum_short_q + SUM_S_W'(price_in) - SUM_S_W'(old_s);
         wr_ptr_d    = wr_ptr_q + 1'b1;
         short_sma_d = sum_short_d[SUM_S_W-1:LOG_S];
         long_sma_d  = sum_long_d[SUM_L_W-1:PTR_W];
         current_d   = price_in;

         case (state_q)
            FILL: begin
               if (fill_cnt_q == LAST_FILL) begin
                  state_d = RUN;
                  valid_d = 1'b1;
               end else begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
            RUN:     valid_d = 1'b1;
            default: state_d = FILL;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values computed above, regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FILL;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         sum_long_q  <= '0;
         sum_short_q <= '0;
         short_sma_q <= '0;
         long_sma_q  <= '0;
         current_q   <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         sum_long_q  <= sum_long_d;
         sum_short_q <= sum_short_d;
         short_sma_q <= short_sma_d;
         long_sma_q  <= long_sma_d;
         current_q   <= current_d;
         valid_q     <= valid_d;
      end
   end

   assign short_sma      = short_sma_q;
   assign long_sma       = long_sma_q;
   assign current_data   = current_q;
   assign data_valid_pre = valid_q;

endmodule : sma_calc
